// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: opcodes, immediate-size codes and
// bit positions inside the architectural flags register.
package exec_pkg;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_OR  = 3'd1;
   localparam logic [2:0] OP_MOV = 3'd2;
   localparam logic [2:0] OP_JMP = 3'd3;
   localparam logic [2:0] OP_SUB = 3'd4;
   localparam logic [2:0] OP_AND = 3'd5;
   localparam logic [2:0] OP_XOR = 3'd6;
   localparam logic [2:0] OP_ADC = 3'd7;

   localparam logic [1:0] IMM_NONE     = 2'd0;
   localparam logic [1:0] IMM_8        = 2'd1;
   localparam logic [1:0] IMM_FULL     = 2'd2;
   localparam logic [1:0] IMM_FULL_ALT = 2'd3;

   localparam int NFLAGS = 5;
   localparam int FL_CF  = 0;
   localparam int FL_AF  = 1;
   localparam int FL_ZF  = 2;
   localparam int FL_SF  = 3;
   localparam int FL_OF  = 4;

   function automatic logic imm_present(input logic [1:0] imm_size);
      return imm_size != IMM_NONE;
   endfunction

endpackage

// File: rtl/exec_obuf.sv
// Two-entry result FIFO between the ALU and writeback. Clear has priority
// over push and pop; the head entry is presented directly from storage.
module exec_obuf #(
   parameter int W = 70
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic [1:0]   count
);

   logic [W-1:0] mem_q [2];
   logic [W-1:0] mem_d [2];
   logic         wr_ptr_q, wr_ptr_d;
   logic         rd_ptr_q, rd_ptr_d;
   logic [1:0]   cnt_q, cnt_d;
   logic         do_push, do_pop;

   always_comb begin
      do_push  = push && (cnt_q != 2'd2);
      do_pop   = pop && (cnt_q != 2'd0);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (clear) begin
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
         cnt_d    = 2'd0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ~wr_ptr_q;
         end
         if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         mem_q[0] <= mem_d[0];
         mem_q[1] <= mem_d[1];
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   assign dout  = mem_q[rd_ptr_q];
   assign count = cnt_q;

endmodule

// File: rtl/exec_stage_p.sv
// Parametrised execute stage: operand select, ALU, flags register, branch
// redirect pulses and a 2-entry output buffer for downstream back-pressure.
module exec_stage_p
   import exec_pkg::*;
#(
   parameter int DW   = 32,
   parameter int TAGW = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_vld,
   output logic              in_rdy,
   input  logic [2:0]        i_op,
   input  logic [DW-1:0]     i_op1_val,
   input  logic [DW-1:0]     i_op2_val,
   input  logic [DW+15:0]    i_imm,
   input  logic [1:0]        i_imm_size,
   input  logic [DW-1:0]     i_eip,
   input  logic              i_far_jmp,
   input  logic [15:0]       i_memoverflow,
   input  logic [DW-1:0]     i_addr,
   input  logic [TAGW-1:0]   i_tag,
   output logic              out_vld,
   input  logic              out_rdy,
   output logic [DW-1:0]     o_result,
   output logic [DW-1:0]     o_addr,
   output logic [TAGW-1:0]   o_tag,
   output logic [NFLAGS-1:0] o_flags,
   output logic [DW-1:0]     o_eip,
   output logic              o_eip_vld,
   output logic [15:0]       o_cs,
   output logic              o_cs_vld
);

   localparam int BW = 2*DW + TAGW;

   logic [NFLAGS-1:0] flags_q, flags_d;
   logic [NFLAGS-1:0] alu_flags;
   logic [DW-1:0]     op1, op2, result, jmp_target;
   logic [DW:0]       sum, diff;
   logic [4:0]        nib_sum, nib_diff;
   logic              cin, is_jmp, imm_here, accept, writes_flags;
   logic              f_cf, f_af, f_of;
   logic [1:0]        count;
   logic [BW-1:0]     buf_dout;

   assign in_rdy  = rst && (count < 2'd2);
   assign out_vld = (count != 2'd0);
   assign accept  = in_vld && in_rdy && !flush;

   always_comb begin
      is_jmp   = (i_op == OP_JMP);
      imm_here = imm_present(i_imm_size);
      op2      = i_op2_val;
      case (i_imm_size)
         IMM_NONE:               op2 = i_op2_val;
         IMM_8:                  op2 = {{(DW-8){i_imm[7]}}, i_imm[7:0]};
         IMM_FULL, IMM_FULL_ALT: op2 = i_imm[DW-1:0];
         default:                op2 = i_op2_val;
      endcase
      op1 = is_jmp ? i_eip : i_op1_val;
      cin = (i_op == OP_ADC) && flags_q[FL_CF];

      // One adder serves ADD/ADC and the near-relative jump target (cin=0 there).
      sum      = {1'b0, op1} + {1'b0, op2} + {{DW{1'b0}}, cin};
      diff     = {1'b0, op1} - {1'b0, op2};
      nib_sum  = {1'b0, op1[3:0]} + {1'b0, op2[3:0]} + {4'b0, cin};
      nib_diff = {1'b0, op1[3:0]} - {1'b0, op2[3:0]};
      jmp_target = (imm_here && !i_far_jmp) ? sum[DW-1:0] : op2;
   end

   always_comb begin
      result       = sum[DW-1:0];
      f_cf         = 1'b0;
      f_af         = 1'b0;
      f_of         = 1'b0;
      writes_flags = 1'b1;
      case (i_op)
         OP_ADD, OP_ADC: begin
            result = sum[DW-1:0];
            f_cf   = sum[DW];
            f_af   = nib_sum[4];
            f_of   = (op1[DW-1] == op2[DW-1]) && (sum[DW-1] != op1[DW-1]);
         end
         OP_SUB: begin
            result = diff[DW-1:0];
            f_cf   = diff[DW];
            f_af   = nib_diff[4];
            f_of   = (op1[DW-1] != op2[DW-1]) && (diff[DW-1] != op1[DW-1]);
         end
         OP_OR:  result = op1 | op2;
         OP_AND: result = op1 & op2;
         OP_XOR: result = op1 ^ op2;
         OP_MOV: begin
            result       = op2;
            writes_flags = 1'b0;
         end
         OP_JMP: begin
            result       = jmp_target;
            writes_flags = 1'b0;
         end
         default: result = sum[DW-1:0];
      endcase
      alu_flags        = '0;
      alu_flags[FL_CF] = f_cf;
      alu_flags[FL_AF] = f_af;
      alu_flags[FL_OF] = f_of;
      alu_flags[FL_ZF] = (result == '0);
      alu_flags[FL_SF] = result[DW-1];
      flags_d = (accept && writes_flags) ? alu_flags : flags_q;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         flags_q <= '0;
      end else begin
         flags_q <= flags_d;
      end
   end

   assign o_flags   = flags_q;
   assign o_eip     = jmp_target;
   assign o_eip_vld = accept && is_jmp;
   assign o_cs_vld  = accept && is_jmp && i_far_jmp;
   assign o_cs      = imm_here ? i_imm[DW+15:DW] : i_memoverflow;

   exec_obuf #(.W(BW)) u_obuf (
      .clk   (clk),
      .rst   (rst),
      .clear (flush),
      .push  (accept),
      .pop   (out_vld && out_rdy),
      .din   ({result, i_addr, i_tag}),
      .dout  (buf_dout),
      .count (count)
   );

   assign o_result = buf_dout[BW-1 -: DW];
   assign o_addr   = buf_dout[TAGW +: DW];
   assign o_tag    = buf_dout[TAGW-1:0];

endmodule

// File: tb/tb_exec_stage_p.sv
// Bench for exec_stage_p: directed scenarios at DW=32 and DW=64 plus a
// randomized run against a queue-based reference model.
module tb_exec_stage_p;
   import exec_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   logic        rst, flush, in_vld, in_rdy, i_far_jmp, out_vld, out_rdy;
   logic [2:0]  i_op;
   logic [31:0] i_op1_val, i_op2_val, i_eip, i_addr;
   logic [47:0] i_imm;
   logic [1:0]  i_imm_size;
   logic [15:0] i_memoverflow, o_cs;
   logic [5:0]  i_tag, o_tag;
   logic [31:0] o_result, o_addr, o_eip;
   logic [4:0]  o_flags;
   logic        o_eip_vld, o_cs_vld;

   logic        w_in_vld, w_in_rdy, w_far, w_out_vld, w_out_rdy, w_oeip_vld, w_cs_vld;
   logic [2:0]  w_op;
   logic [63:0] w_op1, w_op2, w_eip, w_addr, w_result, w_oaddr, w_oeip;
   logic [79:0] w_imm;
   logic [1:0]  w_imm_size;
   logic [15:0] w_memov, w_cs;
   logic [5:0]  w_tag, w_otag;
   logic [4:0]  w_flags;

   exec_stage_p #(.DW(32), .TAGW(6)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_vld(in_vld), .in_rdy(in_rdy),
      .i_op(i_op), .i_op1_val(i_op1_val), .i_op2_val(i_op2_val), .i_imm(i_imm),
      .i_imm_size(i_imm_size), .i_eip(i_eip), .i_far_jmp(i_far_jmp),
      .i_memoverflow(i_memoverflow), .i_addr(i_addr), .i_tag(i_tag),
      .out_vld(out_vld), .out_rdy(out_rdy), .o_result(o_result), .o_addr(o_addr),
      .o_tag(o_tag), .o_flags(o_flags), .o_eip(o_eip), .o_eip_vld(o_eip_vld),
      .o_cs(o_cs), .o_cs_vld(o_cs_vld)
   );

   exec_stage_p #(.DW(64), .TAGW(6)) dut64 (
      .clk(clk), .rst(rst), .flush(1'b0), .in_vld(w_in_vld), .in_rdy(w_in_rdy),
      .i_op(w_op), .i_op1_val(w_op1), .i_op2_val(w_op2), .i_imm(w_imm),
      .i_imm_size(w_imm_size), .i_eip(w_eip), .i_far_jmp(w_far),
      .i_memoverflow(w_memov), .i_addr(w_addr), .i_tag(w_tag),
      .out_vld(w_out_vld), .out_rdy(w_out_rdy), .o_result(w_result), .o_addr(w_oaddr),
      .o_tag(w_otag), .o_flags(w_flags), .o_eip(w_oeip), .o_eip_vld(w_oeip_vld),
      .o_cs(w_cs), .o_cs_vld(w_cs_vld)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [47:0] imm, input logic [1:0] sz, input logic [31:0] eip,
                         input logic far, input logic [31:0] addr, input logic [5:0] tag);
      in_vld = 1'b1; i_op = op; i_op1_val = a; i_op2_val = b; i_imm = imm;
      i_imm_size = sz; i_eip = eip; i_far_jmp = far; i_addr = addr; i_tag = tag;
      i_memoverflow = 16'h0077;
   endtask

   // Reference: architectural result and flags from plain integer arithmetic.
   function automatic void ref_exec(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b, input logic near_rel,
                                    input logic [4:0] fin, output logic [31:0] r,
                                    output logic [4:0] fout);
      longint ua, ub, sa, sb, s, su;
      logic   c, cf, af, of;
      ua = {32'b0, a}; ub = {32'b0, b};
      sa = longint'($signed(a)); sb = longint'($signed(b));
      cf = 1'b0; af = 1'b0; of = 1'b0; r = 32'h0; fout = fin;
      c  = (op == OP_ADC) ? fin[FL_CF] : 1'b0;
      case (op)
         OP_ADD, OP_ADC: begin
            su = ua + ub + longint'(c); r = su[31:0];
            cf = su > 64'hFFFF_FFFF;
            af = ((ua & 15) + (ub & 15) + longint'(c)) > 15;
            s  = sa + sb + longint'(c);
            of = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         OP_SUB: begin
            su = ua - ub; r = su[31:0];
            cf = ua < ub;
            af = (ua & 15) < (ub & 15);
            s  = sa - sb;
            of = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         OP_OR:  r = a | b;
         OP_AND: r = a & b;
         OP_XOR: r = a ^ b;
         OP_MOV: r = b;
         default: r = near_rel ? a + b : b;
      endcase
      if (op != OP_MOV && op != OP_JMP)
         fout = {of, r[31], (r == 32'h0), af, cf};
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h7FFF_FFFF;
         3: return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   task automatic test_reset;
      rst = 1'b0; flush = 1'b0; out_rdy = 1'b0;
      set_in(OP_ADD, 0, 0, 0, IMM_NONE, 0, 0, 0, 0); in_vld = 1'b0;
      w_in_vld = 1'b0; w_op = OP_ADD; w_op1 = 0; w_op2 = 0; w_imm = 0; w_imm_size = IMM_NONE;
      w_eip = 0; w_far = 0; w_memov = 0; w_addr = 0; w_tag = 0; w_out_rdy = 1'b1;
      tick; tick;
      checks++; if (in_rdy !== 1'b0) begin failures++; $display("FAIL reset_in_rdy got=%0h exp=0", in_rdy); end
      checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL reset_out_vld got=%0h exp=0", out_vld); end
      checks++; if (o_flags !== 5'h0) begin failures++; $display("FAIL reset_flags got=%0h exp=0", o_flags); end
      checks++; if (o_result !== 32'h0) begin failures++; $display("FAIL reset_result got=%0h exp=0", o_result); end
      checks++; if (o_addr !== 32'h0 || o_tag !== 6'h0) begin failures++; $display("FAIL reset_addr_tag got=%0h/%0h exp=0/0", o_addr, o_tag); end
      rst = 1'b1; #1;
      checks++; if (in_rdy !== 1'b1) begin failures++; $display("FAIL reset_release_in_rdy got=%0h exp=1", in_rdy); end
   endtask

   task automatic test_add_overflow;
      tick;
      out_rdy = 1'b0;
      set_in(OP_ADD, 32'h7FFF_FFFF, 32'h1, 0, IMM_NONE, 0, 0, 32'h1234, 6'h05); #1;
      checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL add_no_bypass got=%0h exp=0", out_vld); end
      tick; in_vld = 1'b0; #1;
      checks++; if (out_vld !== 1'b1) begin failures++; $display("FAIL add_latency got=%0h exp=1", out_vld); end
      checks++; if (o_result !== 32'h8000_0000) begin failures++; $display("FAIL add_result got=%0h exp=80000000", o_result); end
      checks++; if (o_flags !== 5'b11010) begin failures++; $display("FAIL add_flags got=%b exp=11010", o_flags); end
      checks++; if (o_addr !== 32'h1234 || o_tag !== 6'h05) begin failures++; $display("FAIL add_passthru got=%0h/%0h exp=1234/5", o_addr, o_tag); end
      out_rdy = 1'b1; tick;
      checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL add_pop got=%0h exp=0", out_vld); end
   endtask

   task automatic test_sub_adc;
      set_in(OP_SUB, 32'h0, 32'h1, 0, IMM_NONE, 0, 0, 0, 6'h01); tick;
      set_in(OP_ADC, 32'h2, 32'h3, 0, IMM_NONE, 0, 0, 0, 6'h02); #1;
      checks++; if (o_result !== 32'hFFFF_FFFF) begin failures++; $display("FAIL sub_result got=%0h exp=ffffffff", o_result); end
      checks++; if (o_flags !== 5'b01011) begin failures++; $display("FAIL sub_flags got=%b exp=01011", o_flags); end
      tick; in_vld = 1'b0; #1;
      checks++; if (o_result !== 32'h6 || o_tag !== 6'h02) begin failures++; $display("FAIL adc_result got=%0h tag=%0h exp=6 tag=2", o_result, o_tag); end
      checks++; if (o_flags !== 5'b00000) begin failures++; $display("FAIL adc_flags got=%b exp=00000", o_flags); end
      tick;
      checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL adc_drain got=%0h exp=0", out_vld); end
   endtask

   task automatic test_jmp;
      set_in(OP_JMP, 32'hDEAD_0000, 32'h0000_BEEF, 48'h0000_0000_00F0, IMM_8, 32'h1000, 0, 0, 6'h03); #1;
      checks++; if (o_eip_vld !== 1'b1 || o_eip !== 32'h0FF0) begin failures++; $display("FAIL near_jmp got=%0h vld=%0h exp=ff0 vld=1", o_eip, o_eip_vld); end
      checks++; if (o_cs_vld !== 1'b0) begin failures++; $display("FAIL near_cs_vld got=%0h exp=0", o_cs_vld); end
      tick;
      set_in(OP_JMP, 32'h1, 32'h2, 48'h0008_0000_2000, IMM_FULL, 32'h5000, 1, 0, 6'h04); #1;
      checks++; if (o_result !== 32'h0FF0) begin failures++; $display("FAIL near_buffered got=%0h exp=ff0", o_result); end
      checks++; if (o_cs !== 16'h0008 || o_cs_vld !== 1'b1) begin failures++; $display("FAIL far_cs got=%0h vld=%0h exp=8 vld=1", o_cs, o_cs_vld); end
      checks++; if (o_eip !== 32'h2000 || o_eip_vld !== 1'b1) begin failures++; $display("FAIL far_eip got=%0h vld=%0h exp=2000 vld=1", o_eip, o_eip_vld); end
      tick; in_vld = 1'b0; i_far_jmp = 1'b0; #1;
      checks++; if (o_eip_vld !== 1'b0 || o_cs_vld !== 1'b0) begin failures++; $display("FAIL jmp_pulse_len got=%0h/%0h exp=0/0", o_eip_vld, o_cs_vld); end
      checks++; if (o_result !== 32'h2000 || o_flags !== 5'h0) begin failures++; $display("FAIL far_result_flags got=%0h/%b exp=2000/00000", o_result, o_flags); end
      tick;
   endtask

   task automatic test_backpressure;
      out_rdy = 1'b0;
      set_in(OP_MOV, 0, 32'h11, 0, IMM_NONE, 0, 0, 32'hA1, 6'h01); #1;
      checks++; if (in_rdy !== 1'b1) begin failures++; $display("FAIL bp_rdy0 got=%0h exp=1", in_rdy); end
      tick;
      set_in(OP_MOV, 0, 32'h22, 0, IMM_NONE, 0, 0, 32'hA2, 6'h02); #1;
      checks++; if (in_rdy !== 1'b1) begin failures++; $display("FAIL bp_rdy1 got=%0h exp=1", in_rdy); end
      tick;
      set_in(OP_MOV, 0, 32'h33, 0, IMM_NONE, 0, 0, 32'hA3, 6'h03); #1;
      checks++; if (in_rdy !== 1'b0) begin failures++; $display("FAIL bp_full got=%0h exp=0", in_rdy); end
      tick;
      checks++; if (in_rdy !== 1'b0 || o_result !== 32'h11) begin failures++; $display("FAIL bp_hold got rdy=%0h res=%0h exp rdy=0 res=11", in_rdy, o_result); end
      out_rdy = 1'b1; tick;
      checks++; if (in_rdy !== 1'b1 || o_result !== 32'h22) begin failures++; $display("FAIL bp_reopen got rdy=%0h res=%0h exp rdy=1 res=22", in_rdy, o_result); end
      tick; in_vld = 1'b0; #1;
      checks++; if (o_result !== 32'h33 || o_addr !== 32'hA3 || out_vld !== 1'b1) begin failures++; $display("FAIL bp_third got=%0h addr=%0h exp=33 addr=a3", o_result, o_addr); end
      tick;
      checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL bp_drain got=%0h exp=0", out_vld); end
   endtask

   task automatic test_flush;
      out_rdy = 1'b0;
      set_in(OP_MOV, 0, 32'h44, 0, IMM_NONE, 0, 0, 0, 0); tick;
      set_in(OP_MOV, 0, 32'h55, 0, IMM_NONE, 0, 0, 0, 0); tick;
      set_in(OP_ADD, 32'hFFFF_FFFF, 32'h1, 0, IMM_NONE, 0, 0, 0, 0); flush = 1'b1; tick;
      flush = 1'b0; in_vld = 1'b0; #1;
      checks++; if (out_vld !== 1'b0 || in_rdy !== 1'b1) begin failures++; $display("FAIL flush_full got vld=%0h rdy=%0h exp vld=0 rdy=1", out_vld, in_rdy); end
      set_in(OP_JMP, 0, 0, 48'hF0, IMM_8, 32'h1000, 1, 0, 0); flush = 1'b1; #1;
      checks++; if (o_eip_vld !== 1'b0 || o_cs_vld !== 1'b0) begin failures++; $display("FAIL flush_redirect got=%0h/%0h exp=0/0", o_eip_vld, o_cs_vld); end
      tick;
      set_in(OP_ADD, 32'hFFFF_FFFF, 32'h1, 0, IMM_NONE, 0, 0, 0, 0); tick;
      flush = 1'b0; in_vld = 1'b0; #1;
      checks++; if (out_vld !== 1'b0 || o_flags !== 5'h0) begin failures++; $display("FAIL flush_no_accept got vld=%0h flags=%b exp vld=0 flags=00000", out_vld, o_flags); end
      out_rdy = 1'b1; tick;
   endtask

   task automatic test_dw64;
      w_out_rdy = 1'b1; w_in_vld = 1'b1; w_op = OP_ADD; w_op1 = 64'h7FFF_FFFF_FFFF_FFFF;
      w_op2 = 64'h0; w_imm = 80'h01; w_imm_size = IMM_8; w_addr = 64'hABCD_0000_0000_0001; w_tag = 6'h2A; #1;
      checks++; if (w_in_rdy !== 1'b1) begin failures++; $display("FAIL dw64_rdy got=%0h exp=1", w_in_rdy); end
      tick;
      w_op1 = 64'hFFFF_FFFF_FFFF_FFFF; #1;
      checks++; if (w_result !== 64'h8000_0000_0000_0000 || w_out_vld !== 1'b1) begin failures++; $display("FAIL dw64_add got=%0h exp=8000000000000000", w_result); end
      checks++; if (w_flags !== 5'b11010) begin failures++; $display("FAIL dw64_flags got=%b exp=11010", w_flags); end
      checks++; if (w_oaddr !== 64'hABCD_0000_0000_0001 || w_otag !== 6'h2A) begin failures++; $display("FAIL dw64_passthru got=%0h/%0h", w_oaddr, w_otag); end
      tick;
      w_op = OP_JMP; w_far = 1'b1; w_imm_size = IMM_FULL; w_imm = {16'h0010, 64'h0000_0001_0000_0000}; #1;
      checks++; if (w_result !== 64'h0 || w_flags !== 5'b00111) begin failures++; $display("FAIL dw64_carry got=%0h/%b exp=0/00111", w_result, w_flags); end
      checks++; if (w_oeip !== 64'h1_0000_0000 || w_cs !== 16'h0010 || w_oeip_vld !== 1'b1 || w_cs_vld !== 1'b1) begin failures++; $display("FAIL dw64_far_jmp got=%0h cs=%0h", w_oeip, w_cs); end
      tick; w_in_vld = 1'b0; w_far = 1'b0; tick;
   endtask

   task automatic test_reset_midstream;
      out_rdy = 1'b0;
      set_in(OP_ADD, 32'h7FFF_FFFF, 32'h1, 0, IMM_NONE, 0, 0, 32'h99, 6'h09); tick;
      set_in(OP_MOV, 0, 32'h66, 0, IMM_NONE, 0, 0, 32'h98, 6'h08); tick;
      in_vld = 1'b0; #1;
      checks++; if (out_vld !== 1'b1 || o_flags !== 5'b11010) begin failures++; $display("FAIL midrst_pre got vld=%0h flags=%b", out_vld, o_flags); end
      rst = 1'b0; tick;
      checks++; if (out_vld !== 1'b0 || in_rdy !== 1'b0) begin failures++; $display("FAIL midrst_ctrl got vld=%0h rdy=%0h exp 0/0", out_vld, in_rdy); end
      checks++; if (o_result !== 32'h0 || o_addr !== 32'h0 || o_tag !== 6'h0 || o_flags !== 5'h0) begin failures++; $display("FAIL midrst_data got=%0h/%0h/%0h/%b exp all 0", o_result, o_addr, o_tag, o_flags); end
      rst = 1'b1; #1;
      checks++; if (in_rdy !== 1'b1) begin failures++; $display("FAIL midrst_release got=%0h exp=1", in_rdy); end
   endtask

   task automatic test_random;
      logic [31:0] q_res[$];
      logic [31:0] q_addr[$];
      logic [5:0]  q_tag[$];
      logic [4:0]  mflags, nflags;
      logic [31:0] a, b, r, target;
      logic [15:0] exp_cs;
      logic        acc, pop, near_rel;
      mflags = 5'h0;
      tick;
      for (int n = 0; n < 600; n++) begin
         in_vld = ($urandom_range(0, 3) != 0);
         out_rdy = ($urandom_range(0, 2) != 0);
         flush = ($urandom_range(0, 24) == 0);
         i_op = 3'($urandom_range(0, 7));
         i_op1_val = pick(); i_op2_val = pick();
         i_imm = {16'($urandom), pick()};
         i_imm_size = 2'($urandom_range(0, 3));
         i_eip = $urandom; i_far_jmp = 1'($urandom_range(0, 1));
         i_memoverflow = 16'($urandom); i_addr = $urandom; i_tag = 6'($urandom);
         #1;
         b = (i_imm_size == 2'd0) ? i_op2_val :
             (i_imm_size == 2'd1) ? {{24{i_imm[7]}}, i_imm[7:0]} : i_imm[31:0];
         a = (i_op == OP_JMP) ? i_eip : i_op1_val;
         near_rel = (i_imm_size != 2'd0) && !i_far_jmp;
         target = near_rel ? a + b : b;
         exp_cs = (i_imm_size != 2'd0) ? i_imm[47:32] : i_memoverflow;
         acc = in_vld && !flush && (q_res.size() < 2);
         pop = !flush && (q_res.size() > 0) && out_rdy;
         checks++; if (out_vld !== (q_res.size() != 0)) begin failures++; $display("FAIL rnd_out_vld n=%0d got=%0h exp=%0h", n, out_vld, q_res.size() != 0); end
         checks++; if (in_rdy !== (q_res.size() < 2)) begin failures++; $display("FAIL rnd_in_rdy n=%0d got=%0h exp=%0h", n, in_rdy, q_res.size() < 2); end
         checks++; if (o_flags !== mflags) begin failures++; $display("FAIL rnd_flags n=%0d got=%b exp=%b", n, o_flags, mflags); end
         if (q_res.size() != 0) begin
            checks++; if (o_result !== q_res[0] || o_addr !== q_addr[0] || o_tag !== q_tag[0]) begin failures++; $display("FAIL rnd_head n=%0d got=%0h/%0h/%0h exp=%0h/%0h/%0h", n, o_result, o_addr, o_tag, q_res[0], q_addr[0], q_tag[0]); end
         end
         checks++; if (o_eip_vld !== (acc && i_op == OP_JMP) || o_cs_vld !== (acc && i_op == OP_JMP && i_far_jmp)) begin failures++; $display("FAIL rnd_pulses n=%0d got=%0h/%0h", n, o_eip_vld, o_cs_vld); end
         if (i_op == OP_JMP) begin
            checks++; if (o_eip !== target || o_cs !== exp_cs) begin failures++; $display("FAIL rnd_redirect n=%0d got=%0h/%0h exp=%0h/%0h", n, o_eip, o_cs, target, exp_cs); end
         end
         if (flush) begin
            q_res.delete(); q_addr.delete(); q_tag.delete();
         end else begin
            if (pop) begin
               void'(q_res.pop_front()); void'(q_addr.pop_front()); void'(q_tag.pop_front());
            end
            if (acc) begin
               ref_exec(i_op, a, b, near_rel, mflags, r, nflags);
               q_res.push_back(r); q_addr.push_back(i_addr); q_tag.push_back(i_tag);
               mflags = nflags;
            end
         end
         tick;
      end
      in_vld = 1'b0; flush = 1'b0; out_rdy = 1'b1;
      tick; tick; tick;
      checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL rnd_drain got=%0h exp=0", out_vld); end
   endtask

   initial begin
      test_reset();
      test_add_overflow();
      test_sub_adc();
      test_jmp();
      test_backpressure();
      test_flush();
      test_dw64();
      test_reset_midstream();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/exec_stage_p.md
# exec_stage_p

Parametrised execute stage with valid/ready handshake on both sides. It is the next generation of the fixed 32-bit execute stage and adds:
- configurable data width
- SUB/AND/XOR/ADC operations
- an architectural flags register
- a 2-entry output buffer for back-pressure
- flush
- one-cycle branch-redirect pulses

It sits between decode/operand-fetch and memory/writeback.

## Interface
Parameters:
- DW, 32, datapath width; multiple of 16, at least 16
- TAGW, 6, width of opaque side-band passed to writeback (sr1, isMemwb, …)

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, synchronous, active-low
- flush  in  1  discard buffered and incoming work
- in_vld  in  1  input valid
- in_rdy  out  1  stage can accept
- i_op  in  3  operation code, see Operation
- i_op1_val, i_op2_val  in  DW  register operands
- i_imm  in  DW+16  immediate; [DW+15:DW] = far CS selector
- i_imm_size  in  2  0 none, 1 imm8 sign-extended, 2/3 full DW immediate
- i_eip  in  DW  current instruction pointer
- i_far_jmp  in  1  far jump
- i_memoverflow  in  16  memory-sourced CS selector
- i_addr  in  DW  memory address, passed through
- i_tag  in  TAGW  side-band, passed through
- out_vld  out  1  result valid
- out_rdy  in  1  downstream accepts
- o_result, o_addr  out  DW  ALU result and passed-through address
- o_tag  out  TAGW  passed-through side-band
- o_flags  out  5  {of, sf, zf, af, cf}, registered architectural flags
- o_eip  out  DW  redirect target
- o_eip_vld  out  1  redirect pulse
- o_cs  out  16  CS selector
- o_cs_vld  out  1  far redirect pulse

## Operation
- Accept occurs when in_vld & in_rdy & !flush.
- op2 selection:
  - i_imm_size 0: i_op2_val
  - i_imm_size 1: sext(i_imm[7:0])
  - i_imm_size 2/3: i_imm[DW-1:0]
- op1 selection: i_eip when op=JMP, else i_op1_val.
- Opcodes:
  - 0 ADD: op1+op2
  - 1 OR
  - 2 MOV: op2
  - 3 JMP
  - 4 SUB: op1−op2
  - 5 AND
  - 6 XOR
  - 7 ADC: op1+op2+flags.cf
- JMP:
  - target = op1+op2 when an immediate is present and !i_far_jmp; else op2.
  - o_eip_vld pulses for exactly the accept cycle, combinationally.
  - o_cs_vld = accept & JMP & i_far_jmp.
  - o_cs = i_imm[DW+15:DW] when an immediate is present, else i_memoverflow.
  - The result pushed to the buffer is the target.
- Flags are written at the accept edge:
  - ADD/ADC: cf = carry out of bit DW−1; af = carry out of bit 3; of = signed overflow.
  - SUB: cf = borrow (inverted carry), af = borrow from bit 4, of = signed overflow.
  - Logic ops: cf = of = af = 0.
  - zf = result==0 and sf = result[DW−1] for all arithmetic and logic ops.
  - MOV and JMP leave flags unchanged.
- Output buffer: 2-entry FIFO holding {result, addr, tag}. Each accept pushes one entry; out_vld & out_rdy pops one.
- Flush clears the buffer count and suppresses accept, flag update and redirect in that cycle. Flags already written are kept.

## Timing
- Reset (rst=0 at edge): buffer empty, out_vld=0, flags=0, o_result/o_addr/o_tag=0. in_rdy=0 during the reset cycle, 1 after.
- in_rdy = (count<2). It is registered-only: it does not depend on out_rdy.
- Latency: an input accepted at edge N gives out_vld=1 after edge N (1 cycle) if the buffer was empty.
- Simultaneous push and pop:
  - count 1 stays 1, and the pushed entry is next.
  - count 0: push only; the new entry is not bypassed in the same cycle.
- When full (count 2), in_rdy=0, and one pop reopens it the next cycle.
- Outputs hold stable while out_vld & !out_rdy.
- ADC on back-to-back accepts uses the cf written by the previous accept, with no bubble.
- Flush and reset take effect at the edge. Flush wins over push and pop in the same cycle.

## Structure
- exec_pkg holds:
  - opcode localparams OP_ADD…OP_ADC
  - immediate-size codes
  - flag bit indices FL_CF, FL_AF, FL_ZF, FL_SF, FL_OF
- Sub-module exec_obuf: parametrised 2-entry FIFO of width 2·DW+TAGW with push/pop/clear and count outputs.
- The ALU and the flag generation stay in exec_stage_p.

## Test plan
- ADD, DW=32: op1=0x7FFFFFFF, op2=1 → result 0x80000000, flags of=1 sf=1 cf=0 zf=0 af=1, out_vld one cycle after accept.
- SUB then ADC: 0−1 → 0xFFFFFFFF, cf=1; next ADC 2+3 → 6.
- Near JMP: eip=0x1000, i_imm_size=1, imm8=0xF0 → o_eip=0x0FF0 with o_eip_vld pulse one cycle. Far JMP: imm=0x0008_00002000 → o_cs=0x0008, o_cs_vld=1, o_eip=0x2000.
- Back-pressure: out_rdy=0 with 3 inputs offered → 2 accepted, in_rdy=0. Release → results drain in order, third accepted.
- Flush with 2 buffered and in_vld=1 → out_vld=0 next cycle, no accept, flags unchanged.
- Reset asserted mid-stream → all outputs 0 and buffer empty; DW=64 run of the ADD case with 64-bit overflow.
